// File: rtl/rs_multi_entry.sv
// Multi-entry reservation station: holds renamed instructions, snoops the CDB for
// outstanding source tags and offers the lowest-index ready entry to one FU.
module rs_multi_entry #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 4,
  parameter int unsigned OP_W   = 3,
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [OP_W-1:0]   issue_op,
  input  logic [DATA_W-1:0] issue_vj,
  input  logic [TAG_W-1:0]  issue_qj,
  input  logic [DATA_W-1:0] issue_vk,
  input  logic [TAG_W-1:0]  issue_qk,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              disp_valid,
  input  logic              disp_ready,
  output logic [OP_W-1:0]   disp_op,
  output logic [DATA_W-1:0] disp_vj,
  output logic [DATA_W-1:0] disp_vk,
  output logic [IDX_W-1:0]  disp_idx,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  logic              valid_q [DEPTH];
  logic [OP_W-1:0]   op_q    [DEPTH];
  logic [DATA_W-1:0] vj_q    [DEPTH];
  logic [TAG_W-1:0]  qj_q    [DEPTH];
  logic [DATA_W-1:0] vk_q    [DEPTH];
  logic [TAG_W-1:0]  qk_q    [DEPTH];
  logic [CNT_W-1:0]  count_q;
  logic              lock_q;
  logic [IDX_W-1:0]  lock_idx_q;

  logic              any_ready;
  logic [IDX_W-1:0]  rdy_idx;
  logic [IDX_W-1:0]  free_idx;
  logic [IDX_W-1:0]  sel_idx;
  logic              do_issue;
  logic              accept;

  // Lowest-index ready and free entries; descending scan so the lowest wins.
  always_comb begin
    any_ready = 1'b0;
    rdy_idx   = '0;
    free_idx  = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (valid_q[i] && (qj_q[i] == '0) && (qk_q[i] == '0)) begin
        any_ready = 1'b1;
        rdy_idx   = IDX_W'(i);
      end
      if (!valid_q[i]) free_idx = IDX_W'(i);
    end
  end

  assign full        = (count_q == CNT_W'(DEPTH));
  assign empty       = (count_q == '0);
  assign count       = count_q;
  assign issue_ready = !full;
  assign do_issue    = issue_valid && issue_ready;

  // A locked offer holds its index until the FU accepts it.
  assign sel_idx    = lock_q ? lock_idx_q : rdy_idx;
  assign disp_valid = lock_q || any_ready;
  assign accept     = disp_valid && disp_ready;
  assign disp_idx   = disp_valid ? sel_idx : '0;
  assign disp_op    = disp_valid ? op_q[sel_idx] : '0;
  assign disp_vj    = disp_valid ? vj_q[sel_idx] : '0;
  assign disp_vk    = disp_valid ? vk_q[sel_idx] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        valid_q[i] <= 1'b0;
        op_q[i]    <= '0;
        vj_q[i]    <= '0;
        qj_q[i]    <= '0;
        vk_q[i]    <= '0;
        qk_q[i]    <= '0;
      end
      count_q    <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else if (flush) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        valid_q[i] <= 1'b0;
        op_q[i]    <= '0;
        vj_q[i]    <= '0;
        qj_q[i]    <= '0;
        vk_q[i]    <= '0;
        qk_q[i]    <= '0;
      end
      count_q    <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      // CDB snoop: every waiting operand matching the broadcast captures it.
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (valid_q[i] && cdb_valid) begin
          if ((qj_q[i] != '0) && (qj_q[i] == cdb_tag)) begin
            vj_q[i] <= cdb_data;
            qj_q[i] <= '0;
          end
          if ((qk_q[i] != '0) && (qk_q[i] == cdb_tag)) begin
            vk_q[i] <= cdb_data;
            qk_q[i] <= '0;
          end
        end
      end

      if (accept) begin
        valid_q[sel_idx] <= 1'b0;
        op_q[sel_idx]    <= '0;
        vj_q[sel_idx]    <= '0;
        qj_q[sel_idx]    <= '0;
        vk_q[sel_idx]    <= '0;
        qk_q[sel_idx]    <= '0;
        lock_q           <= 1'b0;
      end else if (disp_valid) begin
        lock_q     <= 1'b1;
        lock_idx_q <= sel_idx;
      end

      // Issue targets a currently free slot, so it never collides with accept.
      if (do_issue) begin
        valid_q[free_idx] <= 1'b1;
        op_q[free_idx]    <= issue_op;
        if (cdb_valid && (issue_qj != '0) && (issue_qj == cdb_tag)) begin
          vj_q[free_idx] <= cdb_data;
          qj_q[free_idx] <= '0;
        end else begin
          vj_q[free_idx] <= issue_vj;
          qj_q[free_idx] <= issue_qj;
        end
        if (cdb_valid && (issue_qk != '0) && (issue_qk == cdb_tag)) begin
          vk_q[free_idx] <= cdb_data;
          qk_q[free_idx] <= '0;
        end else begin
          vk_q[free_idx] <= issue_vk;
          qk_q[free_idx] <= issue_qk;
        end
      end

      case ({do_issue, accept})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: doc/rs_multi_entry.md
Name: rs_multi_entry

Overview:
- Parametrised multi-entry reservation station. Successor to the single-slot add-unit station.
- Holds up to DEPTH renamed instructions and snoops the CDB for outstanding source tags.
- Dispatches ready instructions to one functional unit over a valid/ready handshake.
- Sits between issue logic and one FU instance; one instance per FU class.

Parameters:
DEPTH, 4, number of entries (2..16)
DATA_W, 32, operand width
TAG_W, 4, rename tag width; tag value 0 means "operand present"
OP_W, 3, opcode width

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
flush  in  1  synchronous clear of all entries
issue_valid  in  1  issue request
issue_ready  out  1  station can accept issue this cycle
issue_op  in  OP_W  opcode
issue_vj  in  DATA_W  source j value (meaningful when issue_qj==0)
issue_qj  in  TAG_W  source j producer tag
issue_vk  in  DATA_W  source k value
issue_qk  in  TAG_W  source k producer tag
cdb_valid  in  1  CDB broadcast valid
cdb_tag  in  TAG_W  broadcast tag (never 0 when valid)
cdb_data  in  DATA_W  broadcast value
disp_valid  out  1  an entry is offered to the FU
disp_ready  in  1  FU accepts the offer
disp_op  out  OP_W  offered opcode
disp_vj  out  DATA_W  offered operand j
disp_vk  out  DATA_W  offered operand k
disp_idx  out  clog2(DEPTH)  entry index being offered
count  out  clog2(DEPTH+1)  occupied entries
full  out  1  count==DEPTH
empty  out  1  count==0

Behaviour:
- Reset (rst high, async): all entries invalid; every entry's op/V/Q fields cleared to 0; lock cleared. Outputs: disp_valid=0, disp_op/vj/vk/idx=0, count=0, full=0, empty=1, issue_ready=1.
- Entry fields: valid, op, vj, qj, vk, qk.
- Issue:
  - issue_ready = !full, computed from registered occupancy.
  - A slot freed by dispatch in the same cycle is not reusable that cycle.
  - On issue_valid && issue_ready, write the lowest-index invalid entry at the clock edge.
- Issue-time CDB bypass: if cdb_valid and issue_qj==cdb_tag and issue_qj!=0, the entry stores vj=cdb_data, qj=0. Same rule for k, independently for each operand.
- CDB snoop:
  - Each valid entry with qj==cdb_tag (qj!=0) while cdb_valid captures vj=cdb_data and qj<=0 at the edge. Same for k.
  - All matching entries capture in the same cycle.
- Ready: entry valid && qj==0 && qk==0, evaluated on registered fields. Operands captured from the CDB make the entry eligible no earlier than the next cycle (one-cycle wakeup latency).
- Selection:
  - When unlocked, pick the lowest-index ready entry.
  - disp_valid=1 if one exists; disp_* show that entry's fields, combinationally from registers.
- Lock:
  - If disp_valid && !disp_ready, the selected index is latched and held.
  - disp_op/vj/vk/idx must stay stable until accepted, even if a lower-index entry becomes ready.
- Accept: disp_valid && disp_ready at the edge invalidates that entry, clears its fields, and clears the lock. A new selection is offered the next cycle, giving at most one dispatch per cycle.
- count is the registered occupancy: +1 on issue, −1 on accept; both in one cycle leaves it unchanged.
- Flush:
  - Synchronous; takes priority over issue, snoop and accept in that cycle.
  - Result: all entries invalid, lock cleared, outputs at reset values the next cycle.
  - Flush while disp_valid && disp_ready: the FU owns the handshake result; the station still clears.
- Reset mid-operation: immediate return to reset values regardless of lock or pending CDB.
- Full: issue_valid while full is ignored, with no state change. An empty station never asserts disp_valid.
- Tag 0 on the CDB is illegal; the bench asserts cdb_valid -> cdb_tag!=0.

Test Plan:
1. Reset then issue op=3, qj=0, vj=5, qk=0, vk=7 -> next cycle disp_valid=1, disp_idx=0, disp_op=3, vj=5, vk=7, count=1. With disp_ready=1 that cycle -> next cycle disp_valid=0, count=0, empty=1.
2. Issue qj=4, qk=0, vk=2 -> disp_valid stays 0. cdb_valid, tag=4, data=0x11 in cycle N -> disp_valid=1 in cycle N+1 with vj=0x11.
3. Issue with qk=6 in the same cycle as cdb_valid tag=6, data=0x99 -> entry ready next cycle, vk=0x99 (bypass).
4. Fill DEPTH=4 entries, all waiting on tag 5 -> full=1, issue_ready=0. Extra issue is ignored. Broadcast tag 5 -> all four capture the value. Dispatch order is idx 0,1,2,3 with disp_ready held high, one per cycle.
5. Entry 2 offered and disp_ready=0 for 3 cycles while entry 0 becomes ready -> disp_idx stays 2 with fields stable. On accept, entry 0 is offered next cycle.
6. With 3 entries occupied, assert flush together with issue_valid -> next cycle count=0, empty=1, disp_valid=0. Then assert rst asynchronously mid-lock -> outputs go to reset values immediately.
